// File: rtl/mux4_rr_sampler.sv
// Round-robin sampler steering a 4:1 mux select and registering the
// chosen word, its channel and a one-cycle grant behind valid/ready.
module mux4_rr_sampler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_y,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       ch_q, ch_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       pick;
    logic [1:0]       cand;

    // Scan downward so the smallest offset from last_q+1 wins.
    always_comb begin
        pick = last_q + 2'd1;
        cand = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = last_q + 2'd1 + 2'(i);
            if (req[cand]) pick = cand;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            ch_q    <= 2'd0;
            gnt_q   <= 4'd0;
            vld_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) state_d = SAMPLE;
            end
            SAMPLE: begin
                state_d = req[sel_q] ? HOLD : IDLE;
            end
            HOLD: begin
                if (vld_q && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        last_d = last_q;
        ch_d   = ch_q;
        gnt_d  = 4'd0;
        vld_d  = vld_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (|req) sel_d = pick;
            end
            SAMPLE: begin
                if (req[sel_q]) begin
                    data_d = mux_y;
                    ch_d   = sel_q;
                    vld_d  = 1'b1;
                    gnt_d  = 4'd1 << sel_q;
                    last_d = sel_q;
                end
            end
            HOLD: begin
                if (vld_q && out_ready) vld_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mux4_rr_sampler.md
# mux4_rr_sampler

Round-robin sampler that drives the 2-bit select of the 4-channel, 4-bit-wide 4:1 multiplexer and captures the multiplexer output into a registered valid/ready output stage. It arbitrates among four per-channel requests, steers the mux to the winner, latches the selected word with its channel index, and returns a one-cycle grant to the winning source. It sits directly around the mux: `sel` feeds the mux, and `mux_y` is the mux output.

## Interface
- WIDTH, 4: data width of `mux_y` / `out_data`; must match the mux width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  4  per-channel request; bit i means channel i (mux input a,b,c,d for i=0..3) holds valid data.
- mux_y  input  WIDTH  mux output for the current `sel`.
- out_ready  input  1  downstream ready.
- sel  output  2  registered mux select.
- gnt  output  4  one-hot, one-cycle grant pulse to the channel whose word was captured.
- out_valid  output  1  `out_data` / `out_ch` valid.
- out_data  output  WIDTH  captured word.
- out_ch  output  2  channel index of `out_data`.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Reset is synchronous (rst_n low at a rising edge): state=IDLE, sel=0, last_ch=3, out_valid=0, out_data=0, out_ch=0, gnt=0, busy=0. Reset wins over every other event.
- FSM states are IDLE, SAMPLE, and HOLD.
- IDLE:
  - If req==0, stay in IDLE and hold `sel`.
  - Otherwise pick the first set bit of req scanning from (last_ch+1) mod 4 upward with wrap (3 wraps to 0).
  - Load `sel` with that index and go to SAMPLE.
- SAMPLE (`sel` is stable, so the mux output is settled):
  - If req[sel]==1: capture out_data<=mux_y, out_ch<=sel, set out_valid<=1, pulse gnt[sel]<=1, set last_ch<=sel, and go to HOLD.
  - If req[sel]==0 (request withdrawn): nothing is captured, there is no gnt, last_ch is unchanged, and the FSM returns to IDLE.
- HOLD:
  - gnt returns to 0 after one cycle.
  - out_valid, out_data, and out_ch stay stable until out_valid&&out_ready.
  - On that handshake: out_valid<=0 and the FSM goes to IDLE.
  - req and mux_y are ignored in HOLD.
- Fairness: after channel k is served, every other requesting channel is served before k again. Four continuously requesting channels are served in the order 0,1,2,3,0,…
- Width rules:
  - `sel` and `out_ch` are exactly 2 bits.
  - Round-robin arithmetic is mod 4.
  - `mux_y` is captured unmodified, with no extension or truncation.

## Timing
- Cycle N, state IDLE with req nonzero: `sel` updates at the N→N+1 edge.
- Cycle N+1 is SAMPLE. mux_y is sampled at the N+1→N+2 edge.
- Cycle N+2: out_valid=1, gnt[i]=1 for this one cycle only, busy=1.
- If out_ready=1 in cycle N+2, then in cycle N+3 out_valid=0 and the FSM is in IDLE.
- Minimum period is 3 cycles per transfer (IDLE→SAMPLE→HOLD).
- Latency from the req-sample edge to out_valid is 2 cycles.
- Backpressure: out_ready low holds HOLD indefinitely with outputs stable. There is no loss and no new arbitration.
- Sources must update their mux input or drop req after gnt. A req still high re-enters arbitration in the next IDLE.
- Reset asserted in any state returns all outputs to reset values at that edge. Any in-flight capture is discarded, with no gnt and no out_valid.
- out_ready is ignored unless out_valid=1.

## Test plan
- **Reset values.** Hold rst_n=0 for 2 cycles with req=4'b1111 and out_ready=1. Required: sel=0, out_valid=0, out_data=0, out_ch=0, gnt=0, busy=0 throughout. On release, the first grant goes to channel 0.
- **Single channel.** req=4'b0100, mux_y=4'hA when sel=2, out_ready=1. Required: sel=2 one cycle after req, out_valid=1 with out_data=4'hA, out_ch=2, gnt=4'b0100 two cycles after req, and out_valid=0 the following cycle.
- **Round robin.** req=4'b1111 held, mux_y=sel+4'h5, out_ready=1. Required: out_ch sequence 0,1,2,3,0 with out_data 5,6,7,8,5, one transfer every 3 cycles.
- **Backpressure.** Capture ch1 with data 4'h3, then hold out_ready=0 for 5 cycles while req changes. Required: out_valid, out_data=3, and out_ch=1 stay stable, gnt pulses only once, and the next grant comes only after out_ready=1.
- **Withdrawn request.** req=4'b0010 in IDLE, dropped to 0 during SAMPLE. Required: no gnt, out_valid stays 0, return to IDLE. A later req=4'b0011 grants ch1 first, because last_ch is still 3 and the scan starts at 0.
  - Correction to the expected result above: the scan starts at ch0, so the grant order is ch0 then ch1.
- **Reset mid-transfer.** Assert rst_n=0 in the SAMPLE cycle. Required: no out_valid and no gnt, all outputs at reset values next cycle, and arbitration restarts from ch0.
